// File: rtl/sw_rr_arb_lock_if.sv
// Request/grant bundle between the input VCs and one output-port switch arbiter.
// The arbiter side connects through the slave modport.
interface sw_rr_arb_lock_if #(
    parameter int N = 8
);
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]    req;
    logic [N-1:0]    req_tail;
    logic            out_ready;
    logic [N-1:0]    gnt;
    logic            gnt_valid;
    logic [IDXW-1:0] gnt_idx;
    logic            locked;
    logic [IDXW-1:0] lock_owner;
    logic            timeout_err;

    modport master (
        output req, req_tail, out_ready,
        input  gnt, gnt_valid, gnt_idx, locked, lock_owner, timeout_err
    );

    modport slave (
        input  req, req_tail, out_ready,
        output gnt, gnt_valid, gnt_idx, locked, lock_owner, timeout_err
    );
endinterface

// File: rtl/sw_rr_arb_lock.sv
// Round-robin switch arbiter for one output port; a multi-flit packet holds the
// grant until its tail transfers, with a watchdog that releases an abandoned lock.
module sw_rr_arb_lock #(
    parameter int N            = 8,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               arst,
    sw_rr_arb_lock_if.slave    bus
);
    localparam int IDXW     = (N > 1) ? $clog2(N) : 1;
    localparam int CNTW_RAW = $clog2(LOCK_TIMEOUT + 1);
    localparam int CNTW     = (CNTW_RAW > 1) ? CNTW_RAW : 1;
    localparam logic [CNTW-1:0] WD_LAST = CNTW'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e          state_q,  state_d;
    logic [IDXW-1:0] ptr_q,    ptr_d;
    logic [IDXW-1:0] owner_q,  owner_d;
    logic [CNTW-1:0] wd_cnt_q, wd_cnt_d;
    logic            terr_q,   terr_d;

    logic            rr_found;
    logic [IDXW-1:0] rr_idx;
    logic            gnt_vld;
    logic [IDXW-1:0] gnt_sel;

    function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] i);
        if (int'(i) == N - 1) return '0;
        return i + IDXW'(1);
    endfunction

    // Circular search starting at ptr; candidates are folded back below N.
    always_comb begin : rr_search
        int              cand;
        logic [IDXW-1:0] cand_idx;
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= N) cand = cand - N;
            cand_idx = IDXW'(cand);
            if (!rr_found && bus.req[cand_idx]) begin
                rr_found = 1'b1;
                rr_idx   = cand_idx;
            end
        end
    end

    // Output process: the grant is the transfer, so it is gated by credit and reset.
    always_comb begin : grant_out
        gnt_vld = 1'b0;
        gnt_sel = '0;
        if (!arst && bus.out_ready) begin
            if (state_q == ST_IDLE) begin
                gnt_vld = rr_found;
                gnt_sel = rr_idx;
            end else begin
                gnt_vld = bus.req[owner_q];
                gnt_sel = owner_q;
            end
        end
    end

    assign bus.gnt         = gnt_vld ? (N'(1) << gnt_sel) : '0;
    assign bus.gnt_valid   = gnt_vld;
    assign bus.gnt_idx     = gnt_vld ? gnt_sel : '0;
    assign bus.locked      = (state_q == ST_LOCKED);
    assign bus.lock_owner  = owner_q;
    assign bus.timeout_err = terr_q;

    always_comb begin : next_state
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        wd_cnt_d = wd_cnt_q;
        terr_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    if (bus.req_tail[rr_idx]) begin
                        ptr_d = next_idx(rr_idx);
                    end else begin
                        state_d  = ST_LOCKED;
                        owner_d  = rr_idx;
                        wd_cnt_d = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (gnt_vld) begin
                    wd_cnt_d = '0;
                    if (bus.req_tail[owner_q]) begin
                        state_d = ST_IDLE;
                        ptr_d   = next_idx(owner_q);
                        owner_d = '0;
                    end
                end else if (bus.req[owner_q]) begin
                    // Owner still present but stalled on credit: not abandoned.
                    wd_cnt_d = '0;
                end else if (LOCK_TIMEOUT > 0) begin
                    if (wd_cnt_q == WD_LAST) begin
                        state_d  = ST_IDLE;
                        ptr_d    = next_idx(owner_q);
                        owner_d  = '0;
                        wd_cnt_d = '0;
                        terr_d   = 1'b1;
                    end else begin
                        wd_cnt_d = wd_cnt_q + CNTW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            wd_cnt_q <= '0;
            terr_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            wd_cnt_q <= wd_cnt_d;
            terr_q   <= terr_d;
        end
    end
endmodule
